// File: rtl/pc_sequencer_if.sv
// Request/exception inputs and PC-update control outputs of the PC sequencer.
// The master side drives requests; the sequencer sits on the slave side.
interface pc_sequencer_if;
    logic       req;
    logic [2:0] op_class;
    logic       branch_taken;
    logic [1:0] exc_code;
    logic [2:0] pc_source;
    logic       pc_write;
    logic       epc_write;
    logic       exc_mem_read;
    logic [7:0] exc_addr;
    logic       busy;
    logic       done;

    modport master (
        output req, op_class, branch_taken, exc_code,
        input  pc_source, pc_write, epc_write, exc_mem_read, exc_addr, busy, done
    );

    modport slave (
        input  req, op_class, branch_taken, exc_code,
        output pc_source, pc_write, epc_write, exc_mem_read, exc_addr, busy, done
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC update sequencer: applies end-of-instruction PC updates and runs the
// three-cycle exception entry (save EPC, fetch vector byte, load PC).
module pc_sequencer (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        UPD,
        EXC_SAVE,
        EXC_WAIT,
        EXC_LOAD
    } state_t;

    state_t     state_reg;
    logic [1:0] exc_pend_reg;
    logic       hold_valid_reg;
    logic [1:0] hold_code_reg;

    logic [2:0] pc_source_reg;
    logic       pc_write_reg;
    logic       epc_write_reg;
    logic       exc_mem_read_reg;
    logic [7:0] exc_addr_reg;
    logic       busy_reg;
    logic       done_reg;

    logic       start_exc;
    logic [1:0] start_code;
    logic [2:0] req_sel;
    logic       req_upd;
    logic       req_nop;

    // Exception source in IDLE: held code first, then a live code, then a reserved op_class.
    always_comb begin
        start_exc  = 1'b0;
        start_code = 2'b00;
        if (hold_valid_reg) begin
            start_exc  = 1'b1;
            start_code = hold_code_reg;
        end else if (bus.exc_code != 2'b00) begin
            start_exc  = 1'b1;
            start_code = bus.exc_code;
        end else if (bus.req && (bus.op_class > 3'd4)) begin
            start_exc  = 1'b1;
            start_code = 2'b01;
        end
    end

    always_comb begin
        req_sel = 3'b000;
        req_upd = 1'b0;
        req_nop = 1'b0;
        if (bus.req) begin
            case (bus.op_class)
                3'b000: begin req_sel = 3'b001; req_upd = 1'b1; end
                3'b001: begin
                    if (bus.branch_taken) begin
                        req_sel = 3'b100;
                        req_upd = 1'b1;
                    end else begin
                        req_nop = 1'b1;
                    end
                end
                3'b010: begin req_sel = 3'b110; req_upd = 1'b1; end
                3'b011: begin req_sel = 3'b111; req_upd = 1'b1; end
                3'b100: begin req_sel = 3'b010; req_upd = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= IDLE;
            exc_pend_reg     <= 2'b00;
            hold_valid_reg   <= 1'b0;
            hold_code_reg    <= 2'b00;
            pc_source_reg    <= 3'b000;
            pc_write_reg     <= 1'b0;
            epc_write_reg    <= 1'b0;
            exc_mem_read_reg <= 1'b0;
            exc_addr_reg     <= 8'd0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            pc_source_reg    <= 3'b000;
            pc_write_reg     <= 1'b0;
            epc_write_reg    <= 1'b0;
            exc_mem_read_reg <= 1'b0;
            exc_addr_reg     <= 8'd0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;

            // Only the oldest exception raised while busy is kept.
            if ((state_reg != IDLE) && (bus.exc_code != 2'b00) && !hold_valid_reg) begin
                hold_valid_reg <= 1'b1;
                hold_code_reg  <= bus.exc_code;
            end

            // Outputs are set for the state being entered.
            case (state_reg)
                IDLE: begin
                    if (start_exc) begin
                        state_reg        <= EXC_SAVE;
                        exc_pend_reg     <= start_code;
                        hold_valid_reg   <= 1'b0;
                        pc_source_reg    <= 3'b001;
                        epc_write_reg    <= 1'b1;
                        exc_mem_read_reg <= 1'b1;
                        exc_addr_reg     <= {6'b111111, start_code};
                        busy_reg         <= 1'b1;
                    end else if (req_upd) begin
                        state_reg     <= UPD;
                        pc_source_reg <= req_sel;
                        pc_write_reg  <= 1'b1;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b1;
                    end else if (req_nop) begin
                        done_reg <= 1'b1;
                    end
                end
                UPD: begin
                    state_reg <= IDLE;
                end
                EXC_SAVE: begin
                    state_reg        <= EXC_WAIT;
                    exc_mem_read_reg <= 1'b1;
                    exc_addr_reg     <= {6'b111111, exc_pend_reg};
                    busy_reg         <= 1'b1;
                end
                EXC_WAIT: begin
                    state_reg     <= EXC_LOAD;
                    pc_source_reg <= 3'b101;
                    pc_write_reg  <= 1'b1;
                    done_reg      <= 1'b1;
                    busy_reg      <= 1'b1;
                end
                EXC_LOAD: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.pc_source    = pc_source_reg;
    assign bus.pc_write     = pc_write_reg;
    assign bus.epc_write    = epc_write_reg;
    assign bus.exc_mem_read = exc_mem_read_reg;
    assign bus.exc_addr     = exc_addr_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, checked
// cycle by cycle against a timeline model of scheduled output records.
module tb_pc_sequencer;
    logic clk;
    logic reset;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [2:0] src;
        logic       pcw;
        logic       epcw;
        logic       rd;
        logic [7:0] addr;
        logic       busy;
        logic       done;
    } rec_t;

    rec_t       q[$];
    rec_t       cur;
    logic       pend_v;
    logic [1:0] pend_c;
    int         total;
    int         bad;

    function automatic logic [2:0] sel_of(input logic [2:0] op);
        case (op)
            3'd0:    return 3'd1;
            3'd1:    return 3'd4;
            3'd2:    return 3'd6;
            3'd3:    return 3'd7;
            default: return 3'd2;
        endcase
    endfunction

    task automatic push_exc(input logic [1:0] code);
        rec_t r;
        logic [7:0] a;
        a = 8'(252 + int'(code));
        r = '0; r.src = 3'd1; r.epcw = 1'b1; r.rd = 1'b1; r.addr = a; r.busy = 1'b1;
        q.push_back(r);
        r = '0; r.rd = 1'b1; r.addr = a; r.busy = 1'b1;
        q.push_back(r);
        r = '0; r.src = 3'd5; r.pcw = 1'b1; r.done = 1'b1; r.busy = 1'b1;
        q.push_back(r);
    endtask

    task automatic model_step(input logic r, input logic rq, input logic [2:0] op,
                              input logic bt, input logic [1:0] ec);
        rec_t nxt;
        nxt = '0;
        if (!r) begin
            q.delete();
            pend_v = 1'b0;
            pend_c = 2'b00;
            cur    = '0;
            return;
        end
        if (cur.busy) begin
            if (ec != 2'b00 && !pend_v) begin
                pend_v = 1'b1;
                pend_c = ec;
            end
        end else if (pend_v) begin
            push_exc(pend_c);
            pend_v = 1'b0;
        end else if (ec != 2'b00) begin
            push_exc(ec);
        end else if (rq) begin
            if (op > 3'd4) begin
                push_exc(2'b01);
            end else if (op == 3'd1 && !bt) begin
                nxt.done = 1'b1;
            end else begin
                rec_t u;
                u = '0; u.src = sel_of(op); u.pcw = 1'b1; u.done = 1'b1; u.busy = 1'b1;
                q.push_back(u);
            end
        end
        if (q.size() > 0) nxt = q.pop_front();
        cur = nxt;
    endtask

    task automatic check(input string tag);
        total++;
        assert (bus.pc_source === cur.src) else begin
            bad++; $error("FAIL %s pc_source got %0d want %0d", tag, bus.pc_source, cur.src);
        end
        total++;
        assert (bus.pc_write === cur.pcw) else begin
            bad++; $error("FAIL %s pc_write got %0b want %0b", tag, bus.pc_write, cur.pcw);
        end
        total++;
        assert (bus.epc_write === cur.epcw) else begin
            bad++; $error("FAIL %s epc_write got %0b want %0b", tag, bus.epc_write, cur.epcw);
        end
        total++;
        assert (bus.exc_mem_read === cur.rd) else begin
            bad++; $error("FAIL %s exc_mem_read got %0b want %0b", tag, bus.exc_mem_read, cur.rd);
        end
        total++;
        assert (bus.exc_addr === cur.addr) else begin
            bad++; $error("FAIL %s exc_addr got %0d want %0d", tag, bus.exc_addr, cur.addr);
        end
        total++;
        assert (bus.busy === cur.busy) else begin
            bad++; $error("FAIL %s busy got %0b want %0b", tag, bus.busy, cur.busy);
        end
        total++;
        assert (bus.done === cur.done) else begin
            bad++; $error("FAIL %s done got %0b want %0b", tag, bus.done, cur.done);
        end
    endtask

    task automatic step(input logic r, input logic rq, input logic [2:0] op,
                        input logic bt, input logic [1:0] ec, input string tag);
        reset            = r;
        bus.req          = rq;
        bus.op_class     = op;
        bus.branch_taken = bt;
        bus.exc_code     = ec;
        @(posedge clk);
        model_step(r, rq, op, bt, ec);
        #1;
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 1'b0, 2'b00, tag);
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        cur              = '0;
        pend_v           = 1'b0;
        pend_c           = 2'b00;
        reset            = 1'b0;
        bus.req          = 1'b0;
        bus.op_class     = 3'd0;
        bus.branch_taken = 1'b0;
        bus.exc_code     = 2'b00;
        #1;

        $display("txn reset with inputs active");
        step(1'b0, 1'b1, 3'd0, 1'b0, 2'b10, "reset_a");
        step(1'b0, 1'b1, 3'd2, 1'b0, 2'b00, "reset_b");

        $display("txn seq update");
        step(1'b1, 1'b1, 3'd0, 1'b0, 2'b00, "seq_upd");
        idle(1, "seq_idle");

        $display("txn branch taken / not taken");
        step(1'b1, 1'b1, 3'd1, 1'b1, 2'b00, "br_taken");
        idle(1, "br_taken_idle");
        step(1'b1, 1'b1, 3'd1, 1'b0, 2'b00, "br_not_taken");
        idle(1, "br_nt_idle");

        $display("txn overflow exception in idle");
        step(1'b1, 1'b0, 3'd0, 1'b0, 2'b10, "exc10_save");
        idle(3, "exc10_seq");

        $display("txn jump with divide-by-zero during update");
        step(1'b1, 1'b1, 3'd2, 1'b0, 2'b00, "jump_upd");
        step(1'b1, 1'b0, 3'd0, 1'b0, 2'b11, "jump_done");
        idle(5, "jump_pend_exc");

        $display("txn reset during exc_wait");
        step(1'b1, 1'b0, 3'd0, 1'b0, 2'b01, "rst_save");
        idle(1, "rst_wait");
        step(1'b0, 1'b0, 3'd0, 1'b0, 2'b00, "rst_abort");
        idle(3, "rst_after");

        $display("txn reserved op_class");
        step(1'b1, 1'b1, 3'd5, 1'b0, 2'b00, "resv_save");
        idle(3, "resv_seq");

        $display("txn pending keeps oldest code");
        step(1'b1, 1'b0, 3'd0, 1'b0, 2'b01, "pend_first");
        step(1'b1, 1'b0, 3'd0, 1'b0, 2'b10, "pend_keep");
        step(1'b1, 1'b0, 3'd0, 1'b0, 2'b11, "pend_drop");
        idle(6, "pend_service");

        $display("txn req while busy, back-to-back");
        step(1'b1, 1'b1, 3'd0, 1'b0, 2'b00, "b2b_first");
        step(1'b1, 1'b1, 3'd2, 1'b0, 2'b00, "b2b_ignored");
        step(1'b1, 1'b1, 3'd3, 1'b0, 2'b00, "b2b_accept");
        idle(2, "b2b_idle");

        $display("txn pending beats req");
        step(1'b1, 1'b1, 3'd4, 1'b0, 2'b00, "prio_rte");
        step(1'b1, 1'b0, 3'd0, 1'b0, 2'b10, "prio_capture");
        step(1'b1, 1'b1, 3'd0, 1'b0, 2'b00, "prio_pend_wins");
        idle(4, "prio_idle");

        $display("txn random traffic");
        for (int i = 0; i < 2000; i++) begin
            logic       r;
            logic       rq;
            logic [2:0] op;
            logic       bt;
            logic [1:0] ec;
            r  = ($urandom_range(0, 39) != 0);
            rq = ($urandom_range(0, 2) == 0);
            op = 3'($urandom_range(0, 7));
            bt = 1'($urandom_range(0, 1));
            ec = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(r, rq, op, bt, ec, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
